// File: rtl/xg_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xg_mem_arbiter
// Brief    : Burst-granular arbiter sharing one SDRAM controller port between
//            the video memory manager and the CPU/cache port. One owner per
//            4-beat burst, with an IDLE cycle between consecutive grants.
//            Default build: video priority, bounded by MAX_VID_STREAK
//            consecutive contested video grants.
//            Build option XG_ARB_RR_EN: round-robin on contested cycles.
// Revision : 1.0 - initial release
// ============================================================================
module xg_mem_arbiter #(
  parameter int MAX_VID_STREAK = 4,   // 1..15
  parameter int BURST_LEN      = 4    // fixed to match the 2-bit mem_offset
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  // video master
  input  logic        v_req,
  input  logic        v_wren,
  input  logic [16:0] v_addr,
  input  logic [15:0] v_wdata,
  output logic        v_ready,
  // CPU master
  input  logic        c_req,
  input  logic        c_wren,
  input  logic [16:0] c_addr,
  input  logic [15:0] c_wdata,
  output logic        c_ready,
  // read return shared by both masters
  output logic [1:0]  rd_offset,
  output logic [15:0] rd_data,
  // SDRAM controller side
  output logic        mem_req,
  output logic        mem_wren,
  output logic [16:0] mem_addr,
  output logic [15:0] to_mem,
  input  logic        mem_ready,
  input  logic [1:0]  mem_offset,
  input  logic [15:0] from_mem,
  // ownership status
  output logic        grant_v,
  output logic        grant_c
);

  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VID  = 2'd1,
    ST_CPU  = 2'd2
  } state_e;

  state_e          state_q;
  logic            grant_v_q;
  logic            grant_c_q;
  logic            mem_req_q;
  logic [BW-1:0]   beat_q;
  logic            pick_v_d;
  logic            pick_c_d;
  logic            last_beat;

`ifdef XG_ARB_RR_EN
  logic            last_c_q;   // 1: CPU owned the previous burst
`else
  logic [3:0]      streak_q;
  logic [3:0]      streak_d;
`endif

  // Final beat: offset 3, or the beat counter says this is the last beat
  // (guards against a controller that returns offsets out of order).
  assign last_beat = mem_ready &
                     ((mem_offset == 2'd3) || (beat_q == BW'(BURST_LEN - 1)));

`ifdef XG_ARB_RR_EN
  // Round-robin pick: contested cycles go to the master that did not own last.
  always_comb begin
    pick_v_d = 1'b0;
    pick_c_d = 1'b0;
    if (v_req && c_req) begin
      pick_v_d = last_c_q;
      pick_c_d = !last_c_q;
    end else begin
      pick_v_d = v_req;
      pick_c_d = c_req;
    end
  end
`else
  // Video-priority pick with a streak limit so a waiting CPU is not starved.
  always_comb begin
    pick_v_d = 1'b0;
    pick_c_d = 1'b0;
    streak_d = streak_q;
    if (v_req && c_req) begin
      if (streak_q < 4'(MAX_VID_STREAK)) begin
        pick_v_d = 1'b1;
        streak_d = streak_q + 4'd1;
      end else begin
        pick_c_d = 1'b1;
        streak_d = 4'd0;
      end
    end else if (v_req) begin
      pick_v_d = 1'b1;
      streak_d = 4'd0;
    end else if (c_req) begin
      pick_c_d = 1'b1;
      streak_d = 4'd0;
    end
  end
`endif

  // Ownership FSM: grants and mem_req are registered, burst ends on final beat.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_v_q <= 1'b0;
      grant_c_q <= 1'b0;
      mem_req_q <= 1'b0;
      beat_q    <= '0;
`ifdef XG_ARB_RR_EN
      last_c_q  <= 1'b1;
`else
      streak_q  <= 4'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          beat_q <= '0;
          if (pick_v_d) begin
            state_q   <= ST_VID;
            grant_v_q <= 1'b1;
            mem_req_q <= 1'b1;
          end else if (pick_c_d) begin
            state_q   <= ST_CPU;
            grant_c_q <= 1'b1;
            mem_req_q <= 1'b1;
          end
`ifdef XG_ARB_RR_EN
          if (pick_v_d || pick_c_d) begin
            last_c_q <= pick_c_d;
          end
`else
          streak_q <= streak_d;
`endif
        end
        ST_VID, ST_CPU: begin
          if (last_beat) begin
            state_q   <= ST_IDLE;
            grant_v_q <= 1'b0;
            grant_c_q <= 1'b0;
            mem_req_q <= 1'b0;
            beat_q    <= '0;
          end else if (mem_ready) begin
            beat_q <= beat_q + BW'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          grant_v_q <= 1'b0;
          grant_c_q <= 1'b0;
          mem_req_q <= 1'b0;
          beat_q    <= '0;
        end
      endcase
    end
  end

  // Route the owner's request fields to the controller; zero when idle.
  always_comb begin
    mem_wren = 1'b0;
    mem_addr = 17'd0;
    to_mem   = 16'd0;
    if (grant_v_q) begin
      mem_wren = v_wren;
      mem_addr = v_addr;
      to_mem   = v_wdata;
    end else if (grant_c_q) begin
      mem_wren = c_wren;
      mem_addr = c_addr;
      to_mem   = c_wdata;
    end
  end

  assign mem_req   = mem_req_q;
  assign grant_v   = grant_v_q;
  assign grant_c   = grant_c_q;
  assign v_ready   = mem_ready & grant_v_q;
  assign c_ready   = mem_ready & grant_c_q;
  assign rd_data   = from_mem;
  assign rd_offset = mem_offset;

endmodule
`default_nettype wire

// File: doc/xg_mem_arbiter.md
Name: xg_mem_arbiter

Overview:
- Shares the single SDRAM controller port between two burst masters: the video memory manager (xgmm, pattern/attribute prefetch) and the CPU/cache port.
- Sits between both masters and the SDRAM controller. It is a burst-granular arbiter: one owner per 4-word burst.
- Video has priority because display fetches are deadline-bound. A streak limit guarantees CPU forward progress.

Parameters:
- MAX_VID_STREAK, 4, max consecutive video grants issued while CPU is waiting; range 1..15.
- BURST_LEN, 4, data beats per burst; fixed at 4 to match the 2-bit mem_offset.

Ports:
- clk_sys  in  1  system/memory clock
- rst_n  in  1  asynchronous active-low reset
- v_req  in  1  video request
- v_wren  in  1  video write enable, held with v_req
- v_addr  in  17  video burst address, held with v_req
- v_wdata  in  16  video write data for the current offset
- v_ready  out  1  beat strobe to video
- c_req  in  1  CPU request
- c_wren  in  1  CPU write enable, held with c_req
- c_addr  in  17  CPU burst address, held with c_req
- c_wdata  in  16  CPU write data for the current offset
- c_ready  out  1  beat strobe to CPU
- rd_offset  out  2  mem_offset passthrough to both masters
- rd_data  out  16  from_mem passthrough to both masters
- mem_req  out  1  to SDRAM controller
- mem_wren  out  1  to SDRAM controller
- mem_addr  out  17  to SDRAM controller
- to_mem  out  16  to SDRAM controller
- mem_ready  in  1  beat strobe from controller
- mem_offset  in  2  beat index from controller
- from_mem  in  16  read data from controller
- grant_v  out  1  video currently owns the port
- grant_c  out  1  CPU currently owns the port

Behaviour:
- Clock and reset: one clock, clk_sys; asynchronous active-low reset rst_n.
- Reset values:
  - State is IDLE.
  - grant_v, grant_c, mem_req and the streak counter are all 0.
  - v_ready, c_ready and mem_wren are 0.
- States:
  - IDLE: no owner; evaluates requests every cycle.
  - VID: video owns the port.
  - CPU: CPU owns the port.
- Arbitration in IDLE, on the registered edge:
  - Only v_req: go to VID.
  - Only c_req: go to CPU.
  - Both, streak < MAX_VID_STREAK: go to VID and increment streak.
  - Both, streak == MAX_VID_STREAK: go to CPU and clear streak.
  - A CPU grant clears streak. A video grant with c_req low clears streak.
- Outputs:
  - mem_req = grant_v | grant_c, registered.
  - Latency: a request seen in IDLE at cycle N gives mem_req high at N+1.
  - mem_wren, mem_addr and to_mem are a combinational mux of the owner's inputs. When idle they are 0.
  - v_ready = mem_ready & grant_v; c_ready = mem_ready & grant_c.
  - rd_data and rd_offset are unconditional passthroughs; masters qualify them with their own ready.
- Burst end:
  - A beat with mem_ready=1 and mem_offset=3 is the final beat.
  - The next state is IDLE and mem_req drops for at least one cycle.
  - A beat counter checks beats; the burst also ends if the counter reaches BURST_LEN, so offset order is not trusted.
- Master contract:
  - Hold req, wren and addr stable from assertion through the final beat.
  - Drop req in the cycle after the final beat. A req still high in IDLE is treated as a new request.
- Owner dropping req mid-burst: ignored. The burst completes and ready beats are still routed to that master.
- Simultaneous final beat and new request from the other master: handled in the following IDLE cycle. There is no back-to-back grant without an IDLE cycle.
- mem_ready while IDLE: ignored; both readies stay 0.
- rst_n asserted mid-burst: immediate return to IDLE, mem_req=0. The SDRAM controller is reset from the same rst_n.

Optional Feature:
- XG_ARB_RR_EN defined: fixed priority and the streak counter are removed.
  - A last_owner flop (reset = CPU) gives contested IDLE cycles to the master that did not own the previous burst.
  - Uncontested requests are granted immediately.
- XG_ARB_RR_EN undefined: video priority with the MAX_VID_STREAK limit, as above.

Test Plan:
- Single video read:
  - Stimulus: v_req=1, v_addr=0x00A40, v_wren=0; controller returns beats at offsets 0..3 with data 0x1111, 0x2222, 0x3333, 0x4444.
  - Required: mem_req rises the cycle after v_req; v_ready pulses 4 times with rd_data matching; c_ready stays 0; mem_req is 0 the cycle after offset 3.
- CPU write:
  - Stimulus: c_req=1, c_wren=1, c_addr=0x1FFFC; c_wdata changes per offset.
  - Required: mem_wren=1; to_mem equals c_wdata on each beat; grant_c=1 for the whole burst.
- Contention, MAX_VID_STREAK=4:
  - Stimulus: v_req and c_req both held high continuously.
  - Required: grant order is V,V,V,V,C,V,V,V,V,C; each grant is separated by an IDLE cycle.
- Mid-burst request:
  - Stimulus: c_req asserted during a video burst at offset 1.
  - Required: no mux change until the burst completes; CPU is granted in the IDLE cycle after the video final beat.
- Reset mid-burst:
  - Stimulus: rst_n low at offset 2.
  - Required: mem_req, grant_v, v_ready and the streak counter are 0 asynchronously; after rst_n rises with no req, IDLE persists.
- Round-robin build (XG_ARB_RR_EN):
  - Stimulus: both masters request continuously from reset.
  - Required: first grant is V, since last_owner resets to CPU; then strict alternation V,C,V,C.
